xunit_m: RTL
============

XUNIT_M -- requirements
Module: xunitM

Interface
REQ-001 Parameter DATA_W, default 32: datapath word width; only 32 is supported.
REQ-002 Parameter DELAY_W, default 10: declared for array-tool compatibility and unused internally.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: reset is synchronous and active-low (rst=0 at a rising clk edge resets).
REQ-005 Port run  input  1: one-cycle start pulse; latches delay0 and arms a new 64-word schedule.
REQ-006 Port in0  input  32: message word W[t] for t=0..15, big-endian as presented by the memory unit.
REQ-007 Port out0  output  32: registered schedule word W[t], t=0..63, feeds the round unit w input.
REQ-008 Port out1  output  32: registered round constant K[t], aligned with out0 (see Configuration).
REQ-009 Port done  output  1: high when the unit is idle or waiting out its delay.
REQ-010 Port delay0  input  8: start delay in cycles, applied after run.

Function
REQ-011 The unit SHALL implement states IDLE, WAIT, LOAD and EXPAND, plus a 6-bit round counter t and an 8-bit delay counter.
REQ-012 On run=1, from any state: delay counter <= delay0, t <= 0, state <= WAIT; run takes priority over all other activity.
REQ-013 In WAIT, a nonzero delay counter SHALL decrement each cycle; at zero, the state SHALL become LOAD on the next edge; delay0=0 gives exactly one WAIT cycle.
REQ-014 In LOAD (t=0..15), each cycle: out0 <= in0, in0 shifts into a 16-word window (newest at index 0), t increments; at t=15 the next state is EXPAND.
REQ-015 In EXPAND (t=16..63), each cycle: out0 <= s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], modulo 2^32; the result shifts into the window; t increments.
REQ-016 s0(x) SHALL equal ROTR7 ^ ROTR18 ^ SHR3; s1(x) SHALL equal ROTR17 ^ ROTR19 ^ SHR10; SHR is a logical shift with zero fill.
REQ-017 After the word with t=63 is registered, the state SHALL return to IDLE; t SHALL NOT wrap to 0 and produce a 65th word.
REQ-018 Latency SHALL be 1: the word for round t appears on out0 the edge after the cycle that consumes in0 (LOAD) or computes it (EXPAND).
REQ-019 out0 and out1 SHALL hold their last values in IDLE and WAIT; the window SHALL be retained until the next LOAD overwrites it.
REQ-020 done SHALL be 1 in IDLE and in WAIT while the delay counter is nonzero, and 0 in LOAD and EXPAND.
REQ-021 A run pulse during LOAD or EXPAND SHALL abort the schedule and restart it per REQ-012; the partial window SHALL be discarded logically.

Reset
REQ-022 On rst=0: state=IDLE, t=0, delay counter=0, out0=0, out1=0, all window words=0, done=1.
REQ-023 Reset asserted mid-schedule SHALL take effect at that edge and override run.

Configuration
REQ-024 Macro XUNITM_KROM_EN defined: a 64-entry SHA-256 K constant ROM indexed by t SHALL drive out1 <= K[t] in the same cycle out0 <= W[t].
REQ-025 Macro XUNITM_KROM_EN undefined: no ROM; out1 SHALL be constant 0, and round constants come from an external memory unit.

Verification
REQ-026 Reset: hold rst=0 for 2 cycles mid-EXPAND -> out0=0, out1=0, done=1, and no further outputs until run.
REQ-027 "abc" block: run, delay0=0; feed in0=0x61626380, then fourteen 0x00000000, then 0x00000018 -> out0 W0..W15 echo the inputs, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, done=1 after W63.
REQ-028 Delay: delay0=5 -> done stays 1 for 5 cycles, then 0; the first in0 is sampled on the 7th cycle after the run edge (WAIT for 5 countdown cycles plus 1 zero cycle); out0 valid one cycle later.
REQ-029 KROM (XUNITM_KROM_EN defined): out1=0x428A2F98 together with W0, and out1=0xC67178F2 together with W63.
REQ-030 Restart: run pulsed at t=30 of an "abc" schedule, then the block is re-fed -> the new W16..W19 match REQ-027 exactly and no stale words appear.
REQ-031 Boundary: after W63, hold in0 random for 10 cycles -> out0 stays at W63, t does not wrap, and done=1.

Source files
------------

// File: rtl/xunit_m_if.sv
// Bus bundle for the message-schedule unit: start/delay/message word in, schedule word, constant and done out.
`timescale 1ns/1ps
interface xunit_m_if #(parameter int DATA_W = 32);
  logic              run;
  logic [7:0]        delay0;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic              done;

  modport master (output run, delay0, in0, input out0, out1, done);
  modport slave  (input run, delay0, in0, output out0, out1, done);
endinterface

// File: rtl/xunit_m.sv
// SHA-256 message-schedule unit: loads W0..W15, expands W16..W63, one word per cycle after a start delay.
// Optional K-constant ROM on out1 is enabled by defining XUNITM_KROM_EN.
`timescale 1ns/1ps
module xunit_m #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 10
) (
  input logic       clk,
  input logic       rst,
  xunit_m_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    LOAD   = 2'd2,
    EXPAND = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic [5:0]        t_r, t_nx_s;
  logic [7:0]        dcnt_r, dcnt_nx_s;
  logic [DATA_W-1:0] out0_r, out0_nx_s;
  logic [DATA_W-1:0] out1_r, out1_nx_s;
  logic [DATA_W-1:0] word_s, expand_s, k_s;
  logic              done_r, done_nx_s, shift_s;
  logic [DATA_W-1:0] win_r [16];
  logic              unused_delay_w_s;

  assign unused_delay_w_s = (DELAY_W > 32'sd0);

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // win_r[k] holds W[t-1-k]; the expansion taps are t-2, t-7, t-15 and t-16.
  assign expand_s = sig1(win_r[1]) + win_r[6] + sig0(win_r[14]) + win_r[15];

`ifdef XUNITM_KROM_EN
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign k_s = K_TAB[t_r];
`else
  assign k_s = {DATA_W{1'b0}};
`endif

  // Next-state, counters and output words; run overrides every state.
  always_comb begin
    state_nx_s = state_r;
    t_nx_s     = t_r;
    dcnt_nx_s  = dcnt_r;
    out0_nx_s  = out0_r;
    out1_nx_s  = out1_r;
    word_s     = bus.in0;
    shift_s    = 1'b0;
    if (bus.run) begin
      state_nx_s = WAIT;
      dcnt_nx_s  = bus.delay0;
      t_nx_s     = 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        WAIT: begin
          if (dcnt_r != 8'd0) begin
            dcnt_nx_s = dcnt_r - 8'd1;
          end else begin
            state_nx_s = LOAD;
          end
        end
        LOAD: begin
          word_s    = bus.in0;
          shift_s   = 1'b1;
          out0_nx_s = bus.in0;
          out1_nx_s = k_s;
          t_nx_s    = t_r + 6'd1;
          if (t_r == 6'd15) begin
            state_nx_s = EXPAND;
          end else begin
            state_nx_s = LOAD;
          end
        end
        EXPAND: begin
          word_s    = expand_s;
          shift_s   = 1'b1;
          out0_nx_s = expand_s;
          out1_nx_s = k_s;
          // t parks at 63 so the schedule never wraps into a 65th word.
          if (t_r == 6'd63) begin
            state_nx_s = IDLE;
          end else begin
            t_nx_s = t_r + 6'd1;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
    done_nx_s = (state_nx_s == IDLE) || ((state_nx_s == WAIT) && (dcnt_nx_s != 8'd0));
  end

  // State, counters, output registers and the 16-word window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      t_r     <= 6'd0;
      dcnt_r  <= 8'd0;
      out0_r  <= {DATA_W{1'b0}};
      out1_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= state_nx_s;
      t_r     <= t_nx_s;
      dcnt_r  <= dcnt_nx_s;
      out0_r  <= out0_nx_s;
      out1_r  <= out1_nx_s;
      done_r  <= done_nx_s;
      if (shift_s) begin
        win_r[0] <= word_s;
        for (int i = 1; i < 16; i++) begin
          win_r[i] <= win_r[i-1];
        end
      end
    end
  end

  assign bus.out0 = out0_r;
  assign bus.out1 = out1_r;
  assign bus.done = done_r;

endmodule
